// File: rtl/trail_rect_if.sv
// Bus bundle between the VGA address generator, the scanner and the colour mux.
// Strobe semantics: pix_valid and out_valid are valid-only strobes with no ready;
// the scanner accepts every pix_valid in SCAN (or together with frame_start)
// and reports each accepted pixel exactly once, two cycles later.
interface trail_rect_if #(
    parameter int NUM_RECT = 4,
    parameter int DIM_W    = 10,
    parameter int ADDR_W   = 19
);
    logic                      frame_start;
    logic                      pix_valid;
    logic [NUM_RECT-1:0]       rect_en;
    logic [NUM_RECT*DIM_W-1:0] rect_x;
    logic [NUM_RECT*DIM_W-1:0] rect_y;
    logic [NUM_RECT*DIM_W-1:0] rect_w;
    logic [NUM_RECT*DIM_W-1:0] rect_h;
    logic                      out_valid;
    logic [ADDR_W-1:0]         out_addr;
    logic [NUM_RECT-1:0]       hit;
    logic                      hit_any;
    logic [3:0]                hit_id;
    logic                      busy;

    modport master (
        output frame_start, pix_valid, rect_en, rect_x, rect_y, rect_w, rect_h,
        input  out_valid, out_addr, hit, hit_any, hit_id, busy
    );

    modport slave (
        input  frame_start, pix_valid, rect_en, rect_x, rect_y, rect_w, rect_h,
        output out_valid, out_addr, hit, hit_any, hit_id, busy
    );
endinterface

// File: rtl/trail_rect_scanner.sv
// Raster-tracking rectangle hit tester: counts col/row of a streamed pixel,
// compares against NUM_RECT frame-shadowed rectangles, two-stage pipeline.
module trail_rect_scanner #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int DIM_W    = 10,
    parameter int NUM_RECT = 4
) (
    input  logic        clock_i,
    input  logic        resetn_i,
    trail_rect_if.slave bus,
    output logic [1:0]  state_o
);
    localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int CMP_W = DIM_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

    state_t                    state_q, state_d;
    logic [COL_W-1:0]          col_q, col_d, base_col;
    logic [ROW_W-1:0]          row_q, row_d, base_row;
    logic [ADDR_W-1:0]         addr_q, addr_d, base_addr;
    logic                      accept, last_pix;

    logic [NUM_RECT-1:0]       sh_en_q;
    logic [NUM_RECT*DIM_W-1:0] sh_x_q, sh_y_q, sh_w_q, sh_h_q;
    logic [NUM_RECT-1:0]       use_en;
    logic [NUM_RECT*DIM_W-1:0] use_x, use_y, use_w, use_h;

    logic [CMP_W-1:0]          cur_col, cur_row, rx, ry, rw, rh;
    logic [NUM_RECT-1:0]       cmp_d;

    logic                      s1_valid_q;
    logic [ADDR_W-1:0]         s1_addr_q;
    logic [NUM_RECT-1:0]       s1_cmp_q;
    logic [3:0]                id_d;

    logic                      out_valid_q, hit_any_q;
    logic [ADDR_W-1:0]         out_addr_q;
    logic [NUM_RECT-1:0]       hit_q;
    logic [3:0]                hit_id_q;

    // A pixel arriving with frame_start is tested against the incoming geometry.
    assign use_en = bus.frame_start ? bus.rect_en : sh_en_q;
    assign use_x  = bus.frame_start ? bus.rect_x  : sh_x_q;
    assign use_y  = bus.frame_start ? bus.rect_y  : sh_y_q;
    assign use_w  = bus.frame_start ? bus.rect_w  : sh_w_q;
    assign use_h  = bus.frame_start ? bus.rect_h  : sh_h_q;

    // Acceptance, raster counter advance and FSM next state.
    always_comb begin
        accept    = bus.pix_valid && (bus.frame_start || state_q == SCAN);
        base_col  = bus.frame_start ? '0 : col_q;
        base_row  = bus.frame_start ? '0 : row_q;
        base_addr = bus.frame_start ? '0 : addr_q;
        last_pix  = (base_col == COL_W'(H_ACTIVE - 1)) && (base_row == ROW_W'(V_ACTIVE - 1));
        col_d     = base_col;
        row_d     = base_row;
        addr_d    = base_addr;
        state_d   = state_q;
        if (accept) begin
            addr_d = base_addr + ADDR_W'(1);
            if (base_col == COL_W'(H_ACTIVE - 1)) begin
                col_d = '0;
                row_d = base_row + ROW_W'(1);
            end else begin
                col_d = base_col + COL_W'(1);
            end
        end
        if (bus.frame_start) state_d = SCAN;
        if (accept && last_pix) state_d = DONE;
    end

    // Per-channel window compares; sums are one bit wider so edges never wrap.
    always_comb begin
        cmp_d   = '0;
        cur_col = CMP_W'(base_col);
        cur_row = CMP_W'(base_row);
        rx = '0;
        ry = '0;
        rw = '0;
        rh = '0;
        for (int i = 0; i < NUM_RECT; i++) begin
            rx = {1'b0, use_x[i*DIM_W +: DIM_W]};
            ry = {1'b0, use_y[i*DIM_W +: DIM_W]};
            rw = {1'b0, use_w[i*DIM_W +: DIM_W]};
            rh = {1'b0, use_h[i*DIM_W +: DIM_W]};
            cmp_d[i] = use_en[i] && (cur_col >= rx) && (cur_col < rx + rw) &&
                       (cur_row >= ry) && (cur_row < ry + rh);
        end
    end

    // Lowest-numbered hitting channel wins the id.
    always_comb begin
        id_d = '0;
        for (int i = NUM_RECT - 1; i >= 0; i--) begin
            if (s1_cmp_q[i]) id_d = 4'(i);
        end
    end

    // FSM state register.
    always_ff @(posedge clock_i) begin
        if (!resetn_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Geometry shadow, reloaded only at frame start.
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            sh_en_q <= '0;
            sh_x_q  <= '0;
            sh_y_q  <= '0;
            sh_w_q  <= '0;
            sh_h_q  <= '0;
        end else if (bus.frame_start) begin
            sh_en_q <= bus.rect_en;
            sh_x_q  <= bus.rect_x;
            sh_y_q  <= bus.rect_y;
            sh_w_q  <= bus.rect_w;
            sh_h_q  <= bus.rect_h;
        end
    end

    // Stage 1: raster counters, pixel address and compare results.
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_cmp_q   <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            s1_valid_q <= accept;
            if (accept) begin
                s1_addr_q <= base_addr;
                s1_cmp_q  <= cmp_d;
            end
        end
    end

    // Stage 2: reported result; hit fields read zero when nothing is reported.
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            hit_q       <= '0;
            hit_any_q   <= 1'b0;
            hit_id_q    <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            hit_q       <= s1_valid_q ? s1_cmp_q : '0;
            hit_any_q   <= s1_valid_q && (|s1_cmp_q);
            hit_id_q    <= s1_valid_q ? id_d : 4'd0;
            if (s1_valid_q) out_addr_q <= s1_addr_q;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.hit       = hit_q;
    assign bus.hit_any   = hit_any_q;
    assign bus.hit_id    = hit_id_q;
    assign bus.busy      = (state_q == SCAN);
    assign state_o       = state_q;
endmodule

// File: tb/tb_trail_rect_scanner.sv
// Directed bench for trail_rect_scanner. A short frame (640 x 8) keeps every
// scan to a few thousand cycles while keeping the real line length.
module tb_trail_rect_scanner;
    localparam int H        = 640;
    localparam int V        = 8;
    localparam int ADDR_W   = 19;
    localparam int DIM_W    = 10;
    localparam int NR       = 4;
    localparam int FRAME    = H * V;

    logic       clock;
    logic       resetn;
    logic [1:0] dbg_state;
    int         cyc;

    int n_checks = 0;
    int n_fail   = 0;
    int pix_n    = 0;

    // Geometry as programmed on the bus (g*) and as the frame should see it (s*).
    int gx[NR], gy[NR], gw[NR], gh[NR];
    bit gen[NR];
    int sx[NR], sy[NR], sw[NR], sh[NR];
    bit sen[NR];

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] addr_log[$];
    logic [NR-1:0]     hit_log[$];
    logic [3:0]        id_log[$];
    logic              any_log[$];
    int                cyc_log[$];

    trail_rect_if #(.NUM_RECT(NR), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

    trail_rect_scanner #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .NUM_RECT(NR)
    ) dut (
        .clock_i (clock),
        .resetn_i(resetn),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // Clock and cycle counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Record every reported pixel away from the active edge.
    always @(negedge clock) begin
        if (bus.out_valid === 1'b1) begin
            addr_log.push_back(bus.out_addr);
            hit_log.push_back(bus.hit);
            id_log.push_back(bus.hit_id);
            any_log.push_back(bus.hit_any);
            cyc_log.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_geom(input int i, input int x, input int y, input int w, input int h, input bit en);
        gx[i] = x; gy[i] = y; gw[i] = w; gh[i] = h; gen[i] = en;
        bus.rect_x[i*DIM_W +: DIM_W] = DIM_W'(x);
        bus.rect_y[i*DIM_W +: DIM_W] = DIM_W'(y);
        bus.rect_w[i*DIM_W +: DIM_W] = DIM_W'(w);
        bus.rect_h[i*DIM_W +: DIM_W] = DIM_W'(h);
        bus.rect_en[i] = en;
    endtask

    task automatic clear_geom();
        for (int i = 0; i < NR; i++) set_geom(i, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic clear_logs();
        exp_q.delete();
        addr_log.delete();
        hit_log.delete();
        id_log.delete();
        any_log.delete();
        cyc_log.delete();
    endtask

    task automatic pulse_frame_start(input bit with_pv);
        for (int i = 0; i < NR; i++) begin
            sx[i] = gx[i]; sy[i] = gy[i]; sw[i] = gw[i]; sh[i] = gh[i]; sen[i] = gen[i];
        end
        bus.frame_start = 1'b1;
        bus.pix_valid   = with_pv;
        pix_n = 0;
        if (with_pv) begin
            exp_q.push_back('0);
            pix_n = 1;
        end
        @(posedge clock); #1;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
    endtask

    task automatic run_pixels(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            bus.pix_valid = 1'b1;
            exp_q.push_back(ADDR_W'(pix_n));
            pix_n++;
            @(posedge clock); #1;
            bus.pix_valid = 1'b0;
            repeat (gap) begin
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic drain();
        repeat (3) begin
            @(posedge clock); #1;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [NR-1:0] model_hit(input int a);
        int c, r;
        logic [NR-1:0] h;
        c = a % H;
        r = a / H;
        h = '0;
        for (int i = 0; i < NR; i++)
            h[i] = sen[i] && (c >= sx[i]) && (c < sx[i] + sw[i]) && (r >= sy[i]) && (r < sy[i] + sh[i]);
        return h;
    endfunction

    // Number of recorded results that disagree with the expected stream.
    function automatic int log_errors();
        int e, n, eid;
        logic [NR-1:0] h;
        e = 0;
        if (addr_log.size() != exp_q.size()) e++;
        n = (addr_log.size() < exp_q.size()) ? addr_log.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            h = model_hit(int'(exp_q[i]));
            eid = 0;
            for (int j = NR - 1; j >= 0; j--) if (h[j]) eid = j;
            if (addr_log[i] !== exp_q[i]) e++;
            if (hit_log[i] !== h) e++;
            if (any_log[i] !== (|h)) e++;
            if (id_log[i] !== 4'(eid)) e++;
        end
        return e;
    endfunction

    function automatic int hit_count(input int ch);
        int n;
        n = 0;
        for (int i = 0; i < hit_log.size(); i++) if (hit_log[i][ch] === 1'b1) n++;
        return n;
    endfunction

    function automatic int first_hit(input int ch);
        for (int i = 0; i < hit_log.size(); i++) if (hit_log[i][ch] === 1'b1) return int'(addr_log[i]);
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int e;
        resetn = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b1;
        bus.rect_en = NR'($urandom_range(0, 15));
        bus.rect_x  = (NR*DIM_W)'($urandom);
        bus.rect_y  = (NR*DIM_W)'($urandom);
        bus.rect_w  = (NR*DIM_W)'($urandom);
        bus.rect_h  = (NR*DIM_W)'($urandom);
        repeat (3) begin
            @(posedge clock); #1;
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_checks++;
        if (bus.hit !== '0 || bus.hit_any !== 1'b0 || bus.hit_id !== 4'd0) begin
            n_fail++; $display("FAIL reset_hit got hit=%b any=%b id=%0d want 0/0/0", bus.hit, bus.hit_any, bus.hit_id);
        end
        n_checks++;
        if (bus.out_addr !== '0) begin n_fail++; $display("FAIL reset_out_addr got %0d want 0", bus.out_addr); end
        n_checks++;
        if (bus.busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state got busy=%b state=%0d want 0/IDLE", bus.busy, dbg_state);
        end
        clear_geom();
        resetn = 1'b1;
        clear_logs();
        repeat (5) begin
            @(posedge clock); #1;
        end
        bus.pix_valid = 1'b0;
        drain();
        e = addr_log.size();
        n_checks++;
        if (e !== 0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL idle_ignores_pix got %0d outputs state=%0d want 0 outputs IDLE", e, dbg_state);
        end
    endtask

    task automatic test_full_frame();
        int e;
        clear_geom();
        set_geom(0, 10, 2, 5, 3, 1'b1);
        clear_logs();
        pulse_frame_start(1'b0);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start got %b want 1", bus.busy); end
        bus.pix_valid = 1'b1;
        exp_q.push_back(ADDR_W'(0));
        @(posedge clock); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_n1 got out_valid=%b want 0", bus.out_valid); end
        exp_q.push_back(ADDR_W'(1));
        @(posedge clock); #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== '0) begin
            n_fail++; $display("FAIL latency_n2 got out_valid=%b addr=%0d want 1/0", bus.out_valid, bus.out_addr);
        end
        pix_n = 2;
        run_pixels(FRAME - 3, 0);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_before_last got %b want 1", bus.busy); end
        run_pixels(1, 0);
        n_checks++;
        if (bus.busy !== 1'b0 || dbg_state !== 2'd2) begin
            n_fail++; $display("FAIL busy_after_last got busy=%b state=%0d want 0/DONE", bus.busy, dbg_state);
        end
        // Extra strobes in DONE must not be reported.
        bus.pix_valid = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
        end
        bus.pix_valid = 1'b0;
        drain();
        e = log_errors();
        n_checks++;
        if (e !== 0) begin n_fail++; $display("FAIL full_frame_stream got %0d errors (%0d outputs) want 0 (%0d)", e, addr_log.size(), FRAME); end
        n_checks++;
        if (hit_count(0) !== 15) begin n_fail++; $display("FAIL full_frame_hits got %0d want 15", hit_count(0)); end
        n_checks++;
        if (first_hit(0) !== 1290) begin n_fail++; $display("FAIL full_frame_first got %0d want 1290", first_hit(0)); end
    endtask

    task automatic test_overlap();
        int e;
        clear_geom();
        set_geom(1, 0, 0, 640, 1, 1'b1);
        set_geom(2, 5, 0, 3, 1, 1'b1);
        clear_logs();
        pulse_frame_start(1'b0);
        run_pixels(645, 0);
        drain();
        e = log_errors();
        n_checks++;
        if (e !== 0) begin n_fail++; $display("FAIL overlap_stream got %0d errors want 0", e); end
        n_checks++;
        if (addr_log.size() < 641) begin
            n_fail++; $display("FAIL overlap_count got %0d outputs want 645", addr_log.size());
        end else begin
            n_checks++;
            if (addr_log[6] !== ADDR_W'(6) || hit_log[6] !== 4'b0110 || id_log[6] !== 4'd1 || any_log[6] !== 1'b1) begin
                n_fail++;
                $display("FAIL overlap_addr6 got addr=%0d hit=%b id=%0d any=%b want 6/0110/1/1",
                         addr_log[6], hit_log[6], id_log[6], any_log[6]);
            end
            n_checks++;
            if (hit_log[640] !== 4'b0000 || id_log[640] !== 4'd0 || any_log[640] !== 1'b0) begin
                n_fail++;
                $display("FAIL overlap_row1 got hit=%b id=%0d any=%b want 0000/0/0", hit_log[640], id_log[640], any_log[640]);
            end
        end
    endtask

    task automatic test_edges();
        int e, others;
        clear_geom();
        set_geom(0, 635, V - 1, 20, 20, 1'b1);
        set_geom(1, 100, 3, 0, 5, 1'b1);
        set_geom(2, 640, 0, 10, 8, 1'b1);
        set_geom(3, 0, 0, 640, 8, 1'b0);
        clear_logs();
        pulse_frame_start(1'b0);
        run_pixels(FRAME, 0);
        drain();
        e = log_errors();
        n_checks++;
        if (e !== 0) begin n_fail++; $display("FAIL edges_stream got %0d errors want 0", e); end
        n_checks++;
        if (hit_count(0) !== 5 || first_hit(0) !== (V - 1) * H + 635) begin
            n_fail++; $display("FAIL edges_clip got count=%0d first=%0d want 5/%0d", hit_count(0), first_hit(0), (V - 1) * H + 635);
        end
        others = hit_count(1) + hit_count(2) + hit_count(3);
        n_checks++;
        if (others !== 0) begin n_fail++; $display("FAIL edges_never got %0d hits on w0/x640/disabled want 0", others); end
    endtask

    task automatic test_shadow();
        int e;
        clear_geom();
        set_geom(0, 1, 0, 4, 1, 1'b1);
        clear_logs();
        pulse_frame_start(1'b0);
        run_pixels(FRAME / 2, 0);
        set_geom(0, 0, 0, 4, 8, 1'b1);
        run_pixels(FRAME - FRAME / 2, 0);
        drain();
        e = log_errors();
        n_checks++;
        if (e !== 0 || hit_count(0) !== 4) begin
            n_fail++; $display("FAIL shadow_hold got %0d errors, %0d hits want 0 errors, 4 hits", e, hit_count(0));
        end
        clear_logs();
        pulse_frame_start(1'b1);
        run_pixels(640, 0);
        drain();
        n_checks++;
        if (addr_log.size() == 0 || addr_log[0] !== '0 || hit_log[0][0] !== 1'b1) begin
            n_fail++; $display("FAIL shadow_fs_with_pix got %0d outputs, first addr/hit0 wrong, want addr 0 hit0 1", addr_log.size());
        end
        e = log_errors();
        n_checks++;
        if (e !== 0 || hit_count(0) !== 5) begin
            n_fail++; $display("FAIL shadow_new_frame got %0d errors, %0d hits want 0 errors, 5 hits", e, hit_count(0));
        end
    endtask

    task automatic test_gapped();
        int e, gaps;
        clear_geom();
        set_geom(0, 10, 2, 5, 3, 1'b1);
        clear_logs();
        pulse_frame_start(1'b0);
        run_pixels(FRAME, 2);
        drain();
        e = log_errors();
        n_checks++;
        if (e !== 0 || hit_count(0) !== 15 || first_hit(0) !== 1290) begin
            n_fail++; $display("FAIL gapped_stream got %0d errors, %0d hits, first %0d want 0/15/1290", e, hit_count(0), first_hit(0));
        end
        gaps = 0;
        for (int i = 1; i < cyc_log.size(); i++) if (cyc_log[i] - cyc_log[i-1] != 3) gaps++;
        n_checks++;
        if (gaps !== 0) begin n_fail++; $display("FAIL gapped_spacing got %0d irregular gaps want 0", gaps); end
    endtask

    task automatic test_reset_midframe();
        int e;
        clear_geom();
        set_geom(0, 0, 0, 640, 8, 1'b1);
        clear_logs();
        pulse_frame_start(1'b0);
        run_pixels(10, 0);
        bus.pix_valid = 1'b1;
        resetn = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL midframe_reset got out_valid=%b busy=%b state=%0d want 0/0/IDLE", bus.out_valid, bus.busy, dbg_state);
        end
        clear_logs();
        resetn = 1'b1;
        repeat (10) begin
            @(posedge clock); #1;
        end
        bus.pix_valid = 1'b0;
        drain();
        n_checks++;
        if (addr_log.size() !== 0) begin n_fail++; $display("FAIL midframe_flush got %0d outputs want 0", addr_log.size()); end
        pulse_frame_start(1'b1);
        drain();
        e = log_errors();
        n_checks++;
        if (e !== 0) begin n_fail++; $display("FAIL restart_after_reset got %0d errors want 0", e); end
    endtask

    initial begin
        resetn          = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.rect_en     = '0;
        bus.rect_x      = '0;
        bus.rect_y      = '0;
        bus.rect_w      = '0;
        bus.rect_h      = '0;
        test_reset();
        test_full_frame();
        test_overlap();
        test_edges();
        test_shadow();
        test_gapped();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
